fifo_rd_stage: RTL and testbench
================================

// Module: fifo_rd_stage
// PURPOSE
//  Read-domain half of the async FIFO. It is the counterpart of the write-pointer block.
//  - Keeps the binary read address and the Gray read pointer.
//  - Flags empty against the synchronized Gray write pointer.
//  - Prefetches the head word into a registered valid/ready output stage (first-word fall-through).
//  Sits between the FIFO memory (async read port) and the read-domain consumer.
// PARAMETERS
//  ADD_WIDTH   3  memory address width; depth = 2**ADD_WIDTH; pointers are ADD_WIDTH+1 bits
//  DATA_WIDTH  8  word width
// PORTS
//  rclk       in   1             read-domain clock, all state on posedge
//  rrst       in   1             asynchronous, active-high reset
//  rq2_wptr   in   ADD_WIDTH+1   Gray write pointer, already 2-flop synchronized into rclk
//  rdata_mem  in   DATA_WIDTH    memory read data; combinational function of raddr
//  raddr      out  ADD_WIDTH     memory read address = rbin[ADD_WIDTH-1:0]
//  rptr       out  ADD_WIDTH+1   registered Gray read pointer, to the write-domain synchronizer
//  rempty     out  1             registered: no unread word in memory (output reg excluded)
//  out_valid  out  1             out_data holds a valid word
//  out_data   out  DATA_WIDTH    head word to consumer
//  out_ready  in   1             consumer accepts out_data this cycle
//  rlevel     out  ADD_WIDTH+1   registered count of words in memory not yet popped
// BEHAVIOUR
//  Reset (rrst=1, immediate, async):
//   - rbin=0, rptr=0, rempty=1, out_valid=0, out_data=0, rlevel=0.
//  Internal signals:
//   - pop     = !rempty & (!out_valid | out_ready).
//   - rbin_nx = rbin + pop, modulo 2**(ADD_WIDTH+1).
//   - rgray_nx = rbin_nx ^ (rbin_nx>>1).
//  Each posedge:
//   - rbin <= rbin_nx
//   - rptr <= rgray_nx
//   - rempty <= (rgray_nx == rq2_wptr)
//  Output stage:
//   - pop: out_data <= rdata_mem (word at the current raddr), out_valid <= 1.
//   - else if out_ready: out_valid <= 0, out_data holds.
//   - else: hold.
//  Handshake:
//   - A word transfers on any edge with out_valid & out_ready.
//   - out_data/out_valid must not change while out_valid & !out_ready.
//   - Pop and transfer on the same edge are allowed; this gives full throughput, one word per cycle.
//  Latency (rq2_wptr goes non-empty before edge N):
//   - rempty falls at edge N.
//   - pop occurs at edge N+1; out_valid rises after edge N+1.
//  rlevel:
//   - rlevel <= gray2bin(rq2_wptr) - rbin_nx, modulo 2**(ADD_WIDTH+1), ADD_WIDTH+1 bits wide.
//   - The value is pessimistic (sync lag) and never exceeds 2**ADD_WIDTH.
//  Boundaries:
//   - Pointer wrap: the MSB toggles every 2**ADD_WIDTH reads; raddr wraps to 0 with no glitch in rptr (Gray, 1 bit/step).
//   - Empty: pop is blocked; rbin and rptr are frozen; no underflow is possible.
//   - Output reg full & !out_ready: pop is blocked even when !rempty.
//   - A full FIFO (rlevel=2**ADD_WIDTH) is legal; the read side never asserts full.
//   - rrst mid-transfer: the held word is discarded, out_valid drops at once, pointers return to 0.
//     The write side must be reset together with this block.
// TESTING
//  1. Reset, rq2_wptr=0 -> rempty=1, out_valid=0, rptr=0, raddr=0, rlevel=0 for 10 cycles.
//  2. rq2_wptr 0->1 (Gray), mem[0]=8'hA5, out_ready=0
//     -> rempty=0 at edge 1; out_valid=1, out_data=A5 after edge 2; rptr=1; rempty=1 after edge 2.
//  3. Fill 8 words (rq2_wptr=Gray(8)=4'b1100), out_ready=1 continuously
//     -> 8 consecutive beats in order, one per cycle; rptr ends at 4'b1100; rempty=1.
//  4. 8 words queued, out_ready toggling 1,0,0,1,...
//     -> out_data stable whenever stalled; no word lost or duplicated; rlevel decrements only on pop.
//  5. Stream 20 words through (2.5 wraps)
//     -> data order preserved; rptr sequence is Gray with single-bit steps; raddr wraps 7->0 twice.
//  6. rrst pulsed while out_valid=1 and 3 words pending
//     -> out_valid=0 and rptr=0 asynchronously; after release with rq2_wptr=0, rempty=1.

Source files
------------

// File: rtl/fifo_rd_stage.sv
// fifo_rd_stage: read-domain pointers, empty flag, fill level and first-word fall-through output register of an async FIFO
module fifo_rd_stage #(
  parameter int ADD_WIDTH  = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [ADD_WIDTH:0]    rq2_wptr,
  input  logic [DATA_WIDTH-1:0] rdata_mem,
  output logic [ADD_WIDTH-1:0]  raddr,
  output logic [ADD_WIDTH:0]    rptr,
  output logic                  rempty,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [ADD_WIDTH:0]    rlevel
);
  logic [ADD_WIDTH:0]    rbin_q, rbin_d, rptr_q, rptr_d, rlevel_q, rlevel_d, wbin;
  logic                  rempty_q, rempty_d, valid_q, valid_d, pop;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  // pop the head word whenever memory holds one and the output register is free or draining
  always_comb begin
    pop      = !rempty_q && (!valid_q || out_ready);
    rbin_d   = rbin_q + {{ADD_WIDTH{1'b0}}, pop};
    rptr_d   = rbin_d ^ (rbin_d >> 1);
    rempty_d = rptr_d == rq2_wptr;
    valid_d  = pop ? 1'b1 : out_ready ? 1'b0 : valid_q;
    data_d   = pop ? rdata_mem : data_q;
  end
  // convert the synchronized Gray write pointer to binary for the level count
  always_comb begin
    wbin = '0;
    for (int i = 0; i <= ADD_WIDTH; i++) wbin[i] = ^(rq2_wptr >> i);
    rlevel_d = wbin - rbin_d;
  end
  // all read-domain state, cleared immediately on reset
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rempty_q <= 1'b1;
      valid_q  <= 1'b0;
      data_q   <= '0;
      rlevel_q <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rempty_q <= rempty_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      rlevel_q <= rlevel_d;
    end
  end
  assign raddr     = rbin_q[ADD_WIDTH-1:0];
  assign rptr      = rptr_q;
  assign rempty    = rempty_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign rlevel    = rlevel_q;
endmodule

// File: tb/tb_fifo_rd_stage.sv
// tb_fifo_rd_stage: vector table, directed corner sequences and randomized traffic against a queue-based model
module tb_fifo_rd_stage;
  logic       rclk = 1'b0, rrst = 1'b1, out_ready = 1'b0;
  logic [3:0] rq2_wptr, rptr, rlevel;
  logic [2:0] raddr;
  logic [7:0] rdata_mem, out_data;
  logic       rempty, out_valid;
  logic [7:0] mem [8];
  int         wtot, rd_cnt, beats, checks, passes, wraps;
  bit         m_valid, m_empty;
  logic [7:0] m_data;
  int         m_level;
  logic [7:0] exp_q [$];
  logic [3:0] prev_ptr;
  logic [2:0] prev_addr;

  typedef struct {
    bit         wr;
    logic [7:0] d;
    bit         rdy;
    bit         v;
    logic [7:0] od;
    bit         e;
    logic [3:0] rp;
    logic [3:0] lv;
  } vec_t;
  vec_t tbl [7];

  function automatic logic [3:0] gray(input int c);
    logic [3:0] b;
    b = 4'(c);
    return b ^ (b >> 1);
  endfunction

  assign rq2_wptr  = gray(wtot);
  assign rdata_mem = mem[raddr];

  fifo_rd_stage #(.ADD_WIDTH(3), .DATA_WIDTH(8)) dut (
    .rclk(rclk), .rrst(rrst), .rq2_wptr(rq2_wptr), .rdata_mem(rdata_mem),
    .raddr(raddr), .rptr(rptr), .rempty(rempty), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .rlevel(rlevel)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
  endtask

  task automatic write(input logic [7:0] d);
    mem[wtot % 8] = d;
    exp_q.push_back(d);
    wtot++;
  endtask

  task automatic model_reset();
    wtot = 0; rd_cnt = 0; m_valid = 0; m_empty = 1; m_data = 0; m_level = 0;
    exp_q.delete();
  endtask

  task automatic tick();
    bit pop;
    if (m_valid && out_ready) begin
      beats++;
      if (exp_q.size() == 0) chk("beat_underflow", 1, 0);
      else chk("beat_data", out_data, exp_q.pop_front());
    end
    pop = !m_empty && (!m_valid || out_ready);
    if (pop) begin
      m_data = mem[rd_cnt % 8];
      m_valid = 1;
      rd_cnt++;
    end else if (out_ready) m_valid = 0;
    m_empty = ((wtot - rd_cnt) % 16) == 0;
    m_level = (wtot - rd_cnt) % 16;
    @(posedge rclk);
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("rempty", rempty, m_empty);
    chk("rptr", rptr, gray(rd_cnt));
    chk("raddr", raddr, rd_cnt % 8);
    chk("rlevel", rlevel, m_level);
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge rclk);
    #1;
    chk("rst_rempty", rempty, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_rptr", rptr, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_rlevel", rlevel, 0);
    chk("rst_data", out_data, 0);
    rrst = 1'b0;
    beats = 0;
  endtask

  initial begin
    tbl[0] = '{1, 8'hA5, 0, 0, 8'h00, 0, 4'd0, 4'd1};
    tbl[1] = '{0, 8'h00, 0, 1, 8'hA5, 1, 4'd1, 4'd0};
    tbl[2] = '{0, 8'h00, 0, 1, 8'hA5, 1, 4'd1, 4'd0};
    tbl[3] = '{1, 8'h3C, 0, 1, 8'hA5, 0, 4'd1, 4'd1};
    tbl[4] = '{0, 8'h00, 0, 1, 8'hA5, 0, 4'd1, 4'd1};
    tbl[5] = '{0, 8'h00, 1, 1, 8'h3C, 1, 4'd3, 4'd0};
    tbl[6] = '{0, 8'h00, 1, 0, 8'h3C, 1, 4'd3, 4'd0};
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    model_reset();
    do_reset();
    repeat (10) tick();
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].wr) write(tbl[i].d);
      out_ready = tbl[i].rdy;
      tick();
      chk("tbl_valid", out_valid, tbl[i].v);
      chk("tbl_data", out_data, tbl[i].od);
      chk("tbl_empty", rempty, tbl[i].e);
      chk("tbl_rptr", rptr, tbl[i].rp);
      chk("tbl_level", rlevel, tbl[i].lv);
    end
    do_reset();
    for (int i = 0; i < 8; i++) write(8'(i * 17 + 3));
    out_ready = 1'b1;
    repeat (10) tick();
    chk("burst_beats", beats, 8);
    chk("burst_rptr", rptr, 4'b1100);
    chk("burst_empty", rempty, 1);
    do_reset();
    for (int i = 0; i < 8; i++) write(8'($urandom));
    for (int i = 0; i < 30; i++) begin
      out_ready = (i % 3) == 0;
      tick();
    end
    chk("stall_beats", beats, 8);
    chk("stall_drained", exp_q.size(), 0);
    do_reset();
    out_ready = 1'b1;
    wraps = 0;
    for (int i = 0; i < 200 && beats < 20; i++) begin
      if (wtot < 20 && wtot - rd_cnt < 8 && $urandom_range(0, 3) != 0) write(8'($urandom));
      prev_ptr = rptr;
      prev_addr = raddr;
      tick();
      chk("gray_step", int'($countones(rptr ^ prev_ptr) <= 1), 1);
      if (prev_addr == 3'd7 && raddr == 3'd0) wraps++;
    end
    chk("stream_beats", beats, 20);
    chk("stream_wraps", wraps, 2);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (wtot - rd_cnt < 8 && $urandom_range(0, 1) != 0) write(8'($urandom));
      out_ready = $urandom_range(0, 2) != 0;
      tick();
    end
    do_reset();
    for (int i = 0; i < 4; i++) write(8'(8'hC0 + i));
    repeat (3) tick();
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_level", rlevel, 3);
    #2 rrst = 1'b1;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_rptr", rptr, 0);
    chk("async_level", rlevel, 0);
    model_reset();
    @(posedge rclk);
    #1 rrst = 1'b0;
    tick();
    chk("post_rst_empty", rempty, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
